// File: rtl/mcnc_ctrl_pkg.sv
// Purpose: shared types and constants for the MCNC stimulus controller.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: controller state encoding, LFSR/MISR tap mask, default seed,
// the "synchronous clear" stimulus word and a one-step shift helper.
package mcnc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from r[15], r[13], r[12], r[10]
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED_C = 16'hACE1;

    // dut_in = {G2, G1, G0}; G0 high holds the DUT in synchronous clear
    localparam logic [2:0]  DUT_IN_CLEAR   = 3'b001;

    // One left shift with the polynomial feedback entering at bit 0.
    function automatic logic [15:0] lfsr_shift(input logic [15:0] r);
        return {r[14:0], ^(r & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mcnc_stim_ctrl_lfsr16.sv
// Purpose: 16-bit Fibonacci shift register with parallel load, enable and XOR input (LFSR or MISR).
// Latency: state updates one clock after load/en; val_nxt shows the value the register takes at the next edge.
// Backpressure: none; load has priority over en, en=0 holds the value.
//
// Ports:
//   clock, reset_n        clock and asynchronous active-low reset (register -> RESET_VAL)
//   load, load_val        parallel load
//   en, xor_in            shift one step and XOR in xor_in (xor_in=0 gives a plain LFSR)
//   val_nxt               next register value, for callers that register outputs from it
module lfsr16
    import mcnc_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = DEFAULT_SEED_C
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    input  logic [15:0] xor_in,
    output logic [15:0] val_nxt
);

    logic [15:0] val_q;
    logic [15:0] val_d;

    always_comb begin
        val_d = val_q;
        if (load) begin
            val_d = load_val;
        end else if (en) begin
            val_d = lfsr_shift(val_q) ^ xor_in;
        end
    end

    assign val_nxt = val_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            val_q <= RESET_VAL;
        end else begin
            val_q <= val_d;
        end
    end

endmodule

// File: rtl/mcnc_stim_ctrl.sv
// Purpose: drives pseudo-random stimulus into an MCNC benchmark DUT and compacts its outputs into a MISR signature.
// Latency: INIT_CYCLES clear cycles + N stimulus cycles + 1 drain cycle, then a one-cycle done pulse.
// Backpressure: none; start is only accepted in IDLE, abort cancels a run without a done pulse.
//
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   start, abort     run request (IDLE only) and run cancel
//   cycles, seed     stimulus length N and LFSR seed, captured when start is accepted
//   dut_in           {G2, G1, G0} to the DUT; G0 is the DUT's synchronous clear
//   dut_out          registered DUT outputs {G67,G133,G118,G66,G132,G117}
//   busy, done       run in progress / completion pulse
//   signature        MISR result, held from done until the next run completes
// All outputs come straight from flops: each is computed from the next-state
// values so it lines up with the state it describes.
module mcnc_stim_ctrl
    import mcnc_ctrl_pkg::*;
#(
    parameter int unsigned INIT_CYCLES  = 2,
    parameter logic [15:0] DEFAULT_SEED = DEFAULT_SEED_C
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] cycles,
    input  logic [15:0] seed,
    output logic [2:0]  dut_in,
    input  logic [5:0]  dut_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature
);

    localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] n_q, n_d;
    logic [2:0]  dut_in_q, dut_in_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] signature_q, signature_d;

    logic        lfsr_load, lfsr_en;
    logic        misr_load, misr_en;
    logic [15:0] lfsr_nxt, misr_nxt;
    logic [15:0] seed_eff;

    assign seed_eff = (seed == 16'h0000) ? DEFAULT_SEED : seed;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        misr_load = 1'b0;
        misr_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d   = ST_INIT;
                    n_d       = cycles;
                    cnt_d     = 16'h0000;
                    lfsr_load = 1'b1;
                    misr_load = 1'b1;
                end
            end

            ST_INIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'h0000;
                end else if (cnt_q == INIT_LAST) begin
                    cnt_d   = 16'h0000;
                    state_d = (n_q == 16'h0000) ? ST_DONE : ST_RUN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'h0000;
                end else begin
                    lfsr_en = 1'b1;
                    // The DUT output seen in the first RUN cycle still reflects
                    // the clear; the sample for the last stimulus lands in DRAIN.
                    misr_en = (cnt_q != 16'h0000);
                    // Compare against N-1 rather than counting down to zero so
                    // N=16'hFFFF runs the full length without wrapping.
                    if (cnt_q == n_q - 16'd1) begin
                        state_d = ST_DRAIN;
                        cnt_d   = 16'h0000;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end

            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    misr_en = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 16'h0000;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, derived from the state being entered
    // ------------------------------------------------------------------
    always_comb begin
        dut_in_d    = DUT_IN_CLEAR;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        signature_d = signature_q;

        case (state_d)
            ST_INIT:  busy_d = 1'b1;
            ST_RUN: begin
                busy_d   = 1'b1;
                dut_in_d = {lfsr_nxt[1], lfsr_nxt[0], 1'b0};
            end
            ST_DRAIN: busy_d = 1'b1;
            ST_DONE: begin
                done_d      = 1'b1;
                signature_d = misr_nxt;
            end
            default: begin
                dut_in_d = DUT_IN_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'h0000;
            n_q         <= 16'h0000;
            dut_in_q    <= DUT_IN_CLEAR;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            signature_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            dut_in_q    <= dut_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            signature_q <= signature_d;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus generator and response compactor
    // ------------------------------------------------------------------
    lfsr16 #(
        .RESET_VAL (DEFAULT_SEED)
    ) u_lfsr (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (lfsr_load),
        .load_val (seed_eff),
        .en       (lfsr_en),
        .xor_in   (16'h0000),
        .val_nxt  (lfsr_nxt)
    );

    lfsr16 #(
        .RESET_VAL (16'h0000)
    ) u_misr (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (misr_load),
        .load_val (16'h0000),
        .en       (misr_en),
        .xor_in   ({10'b0, dut_out}),
        .val_nxt  (misr_nxt)
    );

    assign dut_in    = dut_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = signature_q;

endmodule

// File: tb/tb_mcnc_stim_ctrl.sv
// Purpose: self-checking bench for mcnc_stim_ctrl with a behavioural DUT and signature model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mcnc_stim_ctrl;

    localparam int          INIT  = 2;
    localparam logic [15:0] DSEED = 16'hACE1;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [15:0] cycles;
    logic [15:0] seed;
    logic [5:0]  dut_out;
    logic [2:0]  dut_in;
    logic        busy;
    logic        done;
    logic [15:0] signature;

    always #5 clock = ~clock;

    mcnc_stim_ctrl #(
        .INIT_CYCLES  (INIT),
        .DEFAULT_SEED (DSEED)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .cycles    (cycles),
        .seed      (seed),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .signature (signature)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic        dut_mode;      // 0: dut_out tied to tie_val, 1: behavioural DUT
    logic [5:0]  tie_val;
    logic [5:0]  kmask;
    logic [15:0] last_sig;
    logic [2:0]  prev_in;
    logic [15:0] rc_sig;
    logic [2:0]  rc_first_in;
    logic [15:0] sig_a;

    // Polynomial x^16+x^14+x^13+x^11+1, new bit shifted in at the bottom.
    function automatic logic [15:0] ref_step(input logic [15:0] r);
        logic fb;
        fb = r[15] ^ r[13] ^ r[12] ^ r[10];
        return 16'((32'(r) * 2) % 65536) | {15'b0, fb};
    endfunction

    // Stand-in MCNC DUT: cleared while G0 is high, otherwise a mix of its inputs.
    function automatic logic [5:0] dut_model(input logic [2:0] g);
        if (!dut_mode) return tie_val;
        if (g[0])      return 6'h00;
        return {g, g} ^ kmask;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; the DUT model registers the stimulus seen during the cycle.
    task automatic tick();
        prev_in = dut_in;
        @(posedge clock);
        #1;
        dut_out = dut_model(prev_in);
    endtask

    task automatic run_check(input string tag, input logic [15:0] n, input logic [15:0] sd,
                             input int ab_at);
        logic [15:0] l, m, exp_sig, sig_at_done;
        logic [2:0]  exp_in;
        int          busy_cnt, run_cnt, seq_bad, done_cnt, pos_bad, hold_bad, ab_bad, budget;
        logic        prev_busy, ab_pending, aborted;

        // Expected signature: sample k of the MISR is the DUT response to stimulus k.
        l = (sd == 16'h0000) ? DSEED : sd;
        m = 16'h0000;
        for (int j = 0; j < int'(n); j++) begin
            exp_in = {l[1], l[0], 1'b0};
            m      = ref_step(m) ^ {10'b0, dut_model(exp_in)};
            l      = ref_step(l);
        end
        exp_sig = (ab_at >= 0) ? last_sig : m;

        l = (sd == 16'h0000) ? DSEED : sd;
        busy_cnt = 0; run_cnt = 0; seq_bad = 0; done_cnt = 0;
        pos_bad = 0; hold_bad = 0; ab_bad = 0;
        prev_busy = 1'b0; ab_pending = 1'b0; aborted = 1'b0;
        sig_at_done = 16'h0000;
        rc_first_in = 3'b111;

        cycles = n; seed = sd; abort = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;

        budget = int'(n) + INIT + 8;
        for (int c = 0; c < budget; c++) begin
            if (ab_pending) begin
                if (busy !== 1'b0 || done !== 1'b0) ab_bad++;
                abort      = 1'b0;
                ab_pending = 1'b0;
            end
            if (busy === 1'b1) busy_cnt++;
            if (busy === 1'b1 && dut_in[0] === 1'b0) begin
                if (run_cnt == 0) rc_first_in = dut_in;
                exp_in = {l[1], l[0], 1'b0};
                if (dut_in !== exp_in) seq_bad++;
                l = ref_step(l);
                run_cnt++;
                if (run_cnt == ab_at && !aborted) begin
                    abort      = 1'b1;
                    ab_pending = 1'b1;
                    aborted    = 1'b1;
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (prev_busy !== 1'b1 || busy !== 1'b0) pos_bad++;
                sig_at_done = signature;
            end else if (done_cnt > 0 && busy !== 1'b1 && signature !== sig_at_done) begin
                hold_bad++;
            end
            prev_busy = busy;
            // Start in DONE and while busy must be ignored; cycles/seed churn mid-run.
            if (done === 1'b1) begin
                start = 1'b1;
            end else if (busy === 1'b1) begin
                start  = 1'($urandom_range(0, 1));
                cycles = 16'($urandom);
                seed   = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        abort = 1'b0;

        if (ab_at < 0) begin
            check({tag, ".busy_cycles"}, 32'(busy_cnt), (n == 16'h0000) ? INIT : INIT + int'(n) + 1);
            check({tag, ".run_cycles"},  32'(run_cnt),  32'(n));
            check({tag, ".stim_seq"},    32'(seq_bad),  32'd0);
            check({tag, ".done_pulses"}, 32'(done_cnt), 32'd1);
            check({tag, ".done_pos"},    32'(pos_bad),  32'd0);
            check({tag, ".sig_hold"},    32'(hold_bad), 32'd0);
            check({tag, ".signature"},   32'(signature), 32'(exp_sig));
            last_sig = exp_sig;
        end else begin
            check({tag, ".abort_idle"},  32'(ab_bad),   32'd0);
            check({tag, ".run_cycles"},  32'(run_cnt),  32'(ab_at));
            check({tag, ".stim_seq"},    32'(seq_bad),  32'd0);
            check({tag, ".done_pulses"}, 32'(done_cnt), 32'd0);
            check({tag, ".signature"},   32'(signature), 32'(exp_sig));
        end
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        rc_sig = signature;
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        cycles   = 16'h0000;
        seed     = 16'h0000;
        dut_out  = 6'h00;
        dut_mode = 1'b0;
        tie_val  = 6'h00;
        kmask    = 6'h00;
        last_sig = 16'h0000;
        prev_in  = 3'b001;

        repeat (3) tick();
        check("rst.dut_in",    32'(dut_in),    32'h1);
        check("rst.busy",      32'(busy),      32'h0);
        check("rst.done",      32'(done),      32'h0);
        check("rst.signature", 32'(signature), 32'h0);

        reset_n = 1'b1;
        repeat (5) tick();
        check("idle.dut_in",    32'(dut_in),    32'h1);
        check("idle.busy",      32'(busy),      32'h0);
        check("idle.done",      32'(done),      32'h0);
        check("idle.signature", 32'(signature), 32'h0);

        // abort together with start in IDLE stays idle
        start = 1'b1; abort = 1'b1; cycles = 16'd5;
        tick();
        start = 1'b0; abort = 1'b0;
        check("idle.start_abort", 32'(busy), 32'h0);

        // N=4, seed 1: 7 busy cycles, first stimulus 3'b010
        dut_mode = 1'b1; kmask = 6'($urandom);
        run_check("n4", 16'd4, 16'h0001, -1);
        check("n4.first_in", 32'(rc_first_in), 32'h2);

        // tied DUT outputs
        dut_mode = 1'b0; tie_val = 6'h00;
        run_check("tie0_n100", 16'd100, 16'($urandom), -1);
        tie_val = 6'h01;
        run_check("tie1_n1", 16'd1, 16'($urandom), -1);
        check("tie1_n1.value", 32'(rc_sig), 32'h1);

        // zero-length run
        tie_val = 6'($urandom);
        run_check("n0", 16'd0, 16'($urandom), -1);
        check("n0.value", 32'(rc_sig), 32'h0);

        // randomized runs against the model
        dut_mode = 1'b1;
        for (int r = 0; r < 6; r++) begin
            kmask = 6'($urandom);
            run_check("rand", 16'($urandom_range(1, 200)), 16'($urandom), -1);
        end

        // abort in RUN cycle 10 keeps the previous signature
        run_check("abort", 16'd50, 16'($urandom), 10);

        // zero seed behaves exactly like the default seed
        kmask = 6'h2D;
        run_check("seed0", 16'd30, 16'h0000, -1);
        sig_a = rc_sig;
        run_check("seeddef", 16'd30, DSEED, -1);
        check("seed.equal", 32'(rc_sig), 32'(sig_a));

        // full-length run, no counter wrap
        kmask = 6'($urandom);
        run_check("nmax", 16'hFFFF, 16'($urandom), -1);

        // asynchronous reset in the middle of a run
        cycles = 16'd50; seed = 16'($urandom); start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        check("midrst.pre_busy", 32'(busy), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst.dut_in",    32'(dut_in),    32'h1);
        check("midrst.busy",      32'(busy),      32'h0);
        check("midrst.done",      32'(done),      32'h0);
        check("midrst.signature", 32'(signature), 32'h0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("midrst.idle_busy", 32'(busy),   32'h0);
        check("midrst.idle_in",   32'(dut_in), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
